fifo_ctrl: RTL and testbench

- Control unit for the single-clock FIFO built around the simple dual-port RAM.
- Owns both address pointers, the occupancy count, status flags and error flags.
- Gates raw push/pop requests into a RAM write enable and pointer advances.
- Sits between producer/consumer logic and the RAM; the RAM supplies the data path only.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/wrap_ptr.sv | 16 +
 rtl/fifo_ctrl.sv | 70 +++++++
 tb/tb_fifo_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers, occupancy encoding and default thresholds for the FIFO control slice.
package fifo_pkg;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_AEMPTY_TH = 1;
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } occ_t;
    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) if ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/wrap_ptr.sv
// wrap_ptr: modulo-DEPTH pointer that advances on adv and wraps DEPTH-1 -> 0.
//   clk, reset (async, active-low), adv (advance enable), ptr (current pointer)
module wrap_ptr #(
    parameter int DEPTH = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] ptr
);
    // Explicit wrap: depths need not be powers of two.
    always_ff @(posedge clk or negedge reset)
        if (!reset) ptr <= '0;
        else if (adv) ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy, flag and error control for a single-clock FIFO around a dual-port RAM.
//   clk, reset (async, active-low); push/pop requests; clr_err clears sticky errors
//   we/write_addr/read_addr drive the RAM; count plus full/empty/almost_* status; overflow/underflow sticky errors
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_DEPTH,
    parameter int ADDR_WIDTH = ceil_log2(MEM_DEPTH),
    parameter int AFULL_TH = MEM_DEPTH - 1,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr_err,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int CW = ADDR_WIDTH + 1;
    occ_t state, state_nxt;
    logic push_ok, pop_ok;
    logic [CW-1:0] count_nxt;
    assign full = state == ST_FULL;
    assign empty = state == ST_EMPTY;
    assign almost_full = count >= CW'(AFULL_TH);
    assign almost_empty = count <= CW'(AEMPTY_TH);
    // Gated by reset so the RAM never sees a write strobe while the controller is held in reset.
    assign push_ok = push & ~full & reset;
    assign pop_ok = pop & ~empty;
    assign we = push_ok;
    assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
    wrap_ptr #(.DEPTH(MEM_DEPTH), .W(ADDR_WIDTH)) u_wr (
        .clk(clk), .reset(reset), .adv(push_ok), .ptr(write_addr)
    );
    wrap_ptr #(.DEPTH(MEM_DEPTH), .W(ADDR_WIDTH)) u_rd (
        .clk(clk), .reset(reset), .adv(pop_ok), .ptr(read_addr)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY:   state_nxt = push_ok ? ST_PARTIAL : ST_EMPTY;
            ST_PARTIAL: state_nxt = (push_ok && !pop_ok && count == CW'(MEM_DEPTH - 1)) ? ST_FULL :
                                    (pop_ok && !push_ok && count == CW'(1)) ? ST_EMPTY : ST_PARTIAL;
            ST_FULL:    state_nxt = (pop_ok && !push_ok) ? ST_PARTIAL : ST_FULL;
            default:    state_nxt = ST_EMPTY;
        endcase
    end
    // Error set terms come first so a coincident clr_err cannot mask a new error.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= ST_EMPTY;
            count <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            overflow <= (push & full) | (overflow & ~clr_err);
            underflow <= (pop & empty) | (underflow & ~clr_err);
        end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl at depths 4 and 5.
module tb_fifo_ctrl;
    typedef struct packed {
        logic       we;
        logic [2:0] wa;
        logic [2:0] ra;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
    } snap_t;
    typedef struct {
        int    d;
        string tag;
        snap_t s;
    } ent_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic p4 = 1'b0, q4 = 1'b0, c4 = 1'b0;
    logic p5 = 1'b0, q5 = 1'b0, c5 = 1'b0;
    logic we4, f4, e4, af4, ae4, ov4, ud4;
    logic [1:0] wa4, ra4;
    logic [2:0] cnt4;
    logic we5, f5, e5, af5, ae5, ov5, ud5;
    logic [2:0] wa5, ra5;
    logic [3:0] cnt5;
    snap_t snap4, snap5;
    ent_t sb[$];
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    fifo_ctrl #(.MEM_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .push(p4), .pop(q4), .clr_err(c4),
        .we(we4), .write_addr(wa4), .read_addr(ra4), .count(cnt4),
        .full(f4), .empty(e4), .almost_full(af4), .almost_empty(ae4),
        .overflow(ov4), .underflow(ud4)
    );
    fifo_ctrl #(.MEM_DEPTH(5)) dut5 (
        .clk(clk), .reset(reset), .push(p5), .pop(q5), .clr_err(c5),
        .we(we5), .write_addr(wa5), .read_addr(ra5), .count(cnt5),
        .full(f5), .empty(e5), .almost_full(af5), .almost_empty(ae5),
        .overflow(ov5), .underflow(ud5)
    );
    assign snap4 = {we4, 1'b0, wa4, 1'b0, ra4, 1'b0, cnt4, f4, e4, af4, ae4, ov4, ud4};
    assign snap5 = {we5, wa5, ra5, cnt5, f5, e5, af5, ae5, ov5, ud5};
    function automatic snap_t mk(input logic w, input int wa, input int ra, input int cnt,
                                 input logic f, input logic e, input logic af, input logic ae,
                                 input logic ov, input logic ud);
        return {w, 3'(wa), 3'(ra), 4'(cnt), f, e, af, ae, ov, ud};
    endfunction
    task automatic chk(input string tag, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got we=%b wa=%0d ra=%0d cnt=%0d f=%b e=%b af=%b ae=%b ov=%b ud=%b, want we=%b wa=%0d ra=%0d cnt=%0d f=%b e=%b af=%b ae=%b ov=%b ud=%b",
                     tag, act.we, act.wa, act.ra, act.cnt, act.full, act.empty, act.af, act.ae, act.ovf, act.udf,
                     exp.we, exp.wa, exp.ra, exp.cnt, exp.full, exp.empty, exp.af, exp.ae, exp.ovf, exp.udf);
        end
    endtask
    // Each entry describes the outputs expected just before the next rising edge with the given inputs applied.
    task automatic step(input int d, input logic p, input logic q, input logic c,
                        input string tag, input snap_t e);
        ent_t n;
        @(negedge clk);
        if (d == 4) begin
            p4 = p; q4 = q; c4 = c;
        end else begin
            p5 = p; q5 = q; c5 = c;
        end
        n.d = d;
        n.tag = tag;
        n.s = e;
        sb.push_back(n);
    endtask
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk(e.tag, (e.d == 4) ? snap4 : snap5, e.s);
            end
        end
    end
    initial begin
        step(4, 0, 0, 0, "reset_state", mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        @(posedge clk);
        #1 reset = 1'b1;
        step(4, 1, 0, 0, "fill0", mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        step(4, 1, 0, 0, "fill1", mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        step(4, 1, 0, 0, "fill2", mk(1, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        step(4, 1, 0, 0, "fill3_af", mk(1, 3, 0, 3, 0, 0, 1, 0, 0, 0));
        step(4, 1, 0, 0, "push_full", mk(0, 0, 0, 4, 1, 0, 1, 0, 0, 0));
        step(4, 0, 0, 0, "ovf_set", mk(0, 0, 0, 4, 1, 0, 1, 0, 1, 0));
        step(4, 0, 0, 0, "ovf_hold", mk(0, 0, 0, 4, 1, 0, 1, 0, 1, 0));
        step(4, 0, 0, 1, "ovf_clr", mk(0, 0, 0, 4, 1, 0, 1, 0, 1, 0));
        step(4, 1, 0, 1, "set_vs_clr", mk(0, 0, 0, 4, 1, 0, 1, 0, 0, 0));
        step(4, 0, 0, 1, "set_wins", mk(0, 0, 0, 4, 1, 0, 1, 0, 1, 0));
        step(4, 1, 1, 0, "pushpop_full", mk(0, 0, 0, 4, 1, 0, 1, 0, 0, 0));
        step(4, 0, 0, 1, "after_pp_full", mk(0, 0, 1, 3, 0, 0, 1, 0, 1, 0));
        step(4, 0, 1, 0, "drain3", mk(0, 0, 1, 3, 0, 0, 1, 0, 0, 0));
        step(4, 0, 1, 0, "drain2", mk(0, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        step(4, 0, 1, 0, "drain1", mk(0, 0, 3, 1, 0, 0, 0, 1, 0, 0));
        step(4, 1, 1, 0, "pushpop_empty", mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        step(4, 1, 0, 0, "after_pp_empty", mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 1));
        step(4, 0, 0, 1, "udf_clr", mk(0, 2, 0, 2, 0, 0, 0, 0, 0, 1));
        step(4, 1, 1, 0, "pp_part1", mk(1, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        step(4, 1, 1, 0, "pp_part2", mk(1, 3, 1, 2, 0, 0, 0, 0, 0, 0));
        step(4, 1, 1, 0, "pp_part3", mk(1, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        step(4, 1, 1, 0, "pp_part4", mk(1, 1, 3, 2, 0, 0, 0, 0, 0, 0));
        step(4, 1, 1, 0, "pp_part5", mk(1, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        step(4, 1, 1, 0, "pp_part6", mk(1, 3, 1, 2, 0, 0, 0, 0, 0, 0));
        step(4, 1, 0, 0, "to_three", mk(1, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        step(4, 0, 0, 0, "at_three", mk(0, 1, 2, 3, 0, 0, 1, 0, 0, 0));
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset", snap4, mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        step(4, 0, 0, 0, "reset_hold", mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        @(posedge clk);
        #1 reset = 1'b1;
        step(4, 1, 0, 0, "first_push", mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        step(4, 0, 0, 0, "after_first", mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        step(5, 1, 0, 0, "d5_push0", mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        step(5, 1, 0, 0, "d5_push1", mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        step(5, 1, 0, 0, "d5_push2", mk(1, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        step(5, 1, 0, 0, "d5_push3", mk(1, 3, 0, 3, 0, 0, 0, 0, 0, 0));
        step(5, 1, 0, 0, "d5_push4", mk(1, 4, 0, 4, 0, 0, 1, 0, 0, 0));
        step(5, 0, 1, 0, "d5_pop0", mk(0, 0, 0, 5, 1, 0, 1, 0, 0, 0));
        step(5, 0, 1, 0, "d5_pop1", mk(0, 0, 1, 4, 0, 0, 1, 0, 0, 0));
        step(5, 0, 1, 0, "d5_pop2", mk(0, 0, 2, 3, 0, 0, 0, 0, 0, 0));
        step(5, 0, 1, 0, "d5_pop3", mk(0, 0, 3, 2, 0, 0, 0, 0, 0, 0));
        step(5, 0, 1, 0, "d5_pop4", mk(0, 0, 4, 1, 0, 0, 0, 1, 0, 0));
        step(5, 0, 1, 0, "d5_pop_empty", mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        step(5, 0, 0, 0, "d5_udf", mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
